// File: rtl/mskdata_serializer_low_level_pkg.sv
// rtl/mskdata_serializer_low_level_pkg.sv - sizing helpers and FSM encoding for the masked serializer (optional SMAESH_SERIALIZER_RFRSH_EN)
`ifndef MSKSER_DIVIDES
`define MSKSER_DIVIDES(bits, rate) (((bits) % (rate)) == 0)
`endif

package mskdata_serializer_low_level_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ser_state_t;

    function automatic int nstages(input int bits, input int rate);
        return bits / rate;
    endfunction

    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mskdata_serializer_low_level_if.sv
// rtl/mskdata_serializer_low_level_if.sv - word input, chunk output and refresh-randomness signals of the masked serializer
interface mskdata_serializer_low_level_if #(
    parameter int d          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [d*BITS-1:0]               sh_data_in;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_last;
    logic [d*RFRSH_RATE-1:0]         sh_data_out;
    logic [(d-1)*RFRSH_RATE-1:0]     rnd_rfrsh_in;
    logic                            rnd_ready;

    modport master (
        output in_valid, sh_data_in, out_ready, rnd_rfrsh_in,
        input  in_ready, out_valid, out_last, sh_data_out, rnd_ready
    );

    modport slave (
        input  in_valid, sh_data_in, out_ready, rnd_rfrsh_in,
        output in_ready, out_valid, out_last, sh_data_out, rnd_ready
    );
endinterface

// File: rtl/mskdata_serializer_low_level_refresh.sv
// rtl/mskdata_serializer_low_level_refresh.sv - d-share refresh of a W-bit chunk using (d-1)*W fresh random bits
module mskdata_serializer_low_level_refresh #(
    parameter int d = 2,
    parameter int W = 16
) (
    input  logic [d*W-1:0]     shares_in,
    input  logic [(d-1)*W-1:0] rnd,
    output logic [d*W-1:0]     shares_out
);
    logic [W-1:0] acc;

    // Shares 0..d-2 absorb one random word each; the last share absorbs their XOR.
    always_comb begin
        shares_out = shares_in;
        acc        = '0;
        for (int i = 0; i < d - 1; i++) begin
            shares_out[i*W +: W] = shares_in[i*W +: W] ^ rnd[i*W +: W];
            acc                  = acc ^ rnd[i*W +: W];
        end
        shares_out[(d-1)*W +: W] = shares_in[(d-1)*W +: W] ^ acc;
    end
endmodule

// File: rtl/mskdata_serializer_low_level_stage.sv
// rtl/mskdata_serializer_low_level_stage.sv - one-share chunk register with enable and load/shift select
module mskdata_serializer_low_level_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic [W-1:0] shift_data,
    output logic [W-1:0] q
);
    // Share data is deliberately not reset; only the control path is.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= load ? load_data : shift_data;
        end
    end
endmodule

// File: rtl/mskdata_serializer_low_level.sv
// rtl/mskdata_serializer_low_level.sv - masked word-to-chunk serializer, LS chunk first; SMAESH_SERIALIZER_RFRSH_EN enables chunk refresh
module mskdata_serializer_low_level
    import mskdata_serializer_low_level_pkg::*;
#(
    parameter int d          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    mskdata_serializer_low_level_if.slave bus
);
    localparam int NSTAGES = nstages(BITS, RFRSH_RATE);
    localparam int CW      = count_width(NSTAGES);
    localparam int R       = RFRSH_RATE;
    localparam int CHUNK_W = d * R;
    localparam logic [CW-1:0] LAST_IDX = CW'(NSTAGES - 1);

    if (!`MSKSER_DIVIDES(BITS, RFRSH_RATE)) begin : g_bad_cfg
        $error("RFRSH_RATE must divide BITS");
    end

    ser_state_t      state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            is_last, load, shift, en;

    logic [R-1:0]       sreg [NSTAGES][d];
    logic [CHUNK_W-1:0] s0_shift_flat;
    logic [(d-1)*R-1:0] rnd_used;

    assign is_last       = (state == BUSY) && (count == LAST_IDX);
    assign bus.out_valid = (state == BUSY);
    assign bus.out_last  = is_last;
    assign bus.in_ready  = (state == IDLE) || (is_last && bus.out_ready);
    assign load          = bus.in_valid && bus.in_ready;
    assign shift         = (state == BUSY) && bus.out_ready && !is_last;
    assign en            = load || shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A load always wins: it can coincide with the last-chunk transfer.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = BUSY;
                    count_nxt = '0;
                end
            end
            BUSY: begin
                if (load) begin
                    state_nxt = BUSY;
                    count_nxt = '0;
                end else if (bus.out_ready) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

`ifdef SMAESH_SERIALIZER_RFRSH_EN
    assign rnd_used      = bus.rnd_rfrsh_in;
    assign bus.rnd_ready = shift;
`else
    // Zero randomness turns the refresh tree into a plain wire.
    assign rnd_used      = '0;
    assign bus.rnd_ready = 1'b0;
`endif

    logic unused_rnd;
    assign unused_rnd = ^bus.rnd_rfrsh_in;

    if (NSTAGES > 1) begin : g_feed
        logic [CHUNK_W-1:0] s1_flat;
        for (genvar i = 0; i < d; i++) begin : g_pack
            assign s1_flat[i*R +: R] = sreg[1][i];
        end
        mskdata_serializer_low_level_refresh #(.d(d), .W(R)) u_refresh (
            .shares_in  (s1_flat),
            .rnd        (rnd_used),
            .shares_out (s0_shift_flat)
        );
    end else begin : g_single
        for (genvar i = 0; i < d; i++) begin : g_pack
            assign s0_shift_flat[i*R +: R] = sreg[0][i];
        end
    end

    for (genvar j = 0; j < NSTAGES; j++) begin : g_stage
        for (genvar i = 0; i < d; i++) begin : g_share
            logic [R-1:0] ld, nxt;

            // Sharewise bus: share i of bit k of chunk j sits at (j*R + k)*d + i.
            always_comb begin
                ld = '0;
                for (int b = 0; b < R; b++) begin
                    ld[b] = bus.sh_data_in[(j*R + b)*d + i];
                end
            end

            if (j == 0) begin : g_head
                assign nxt = s0_shift_flat[i*R +: R];
            end else if (j < NSTAGES - 1) begin : g_mid
                assign nxt = sreg[j+1][i];
            end else begin : g_tail
                assign nxt = sreg[j][i];
            end

            mskdata_serializer_low_level_stage #(.W(R)) u_stage (
                .clk        (clk),
                .en         (en),
                .load       (load),
                .load_data  (ld),
                .shift_data (nxt),
                .q          (sreg[j][i])
            );
        end
    end

    always_comb begin
        bus.sh_data_out = '0;
        for (int b = 0; b < R; b++) begin
            for (int i = 0; i < d; i++) begin
                bus.sh_data_out[b*d + i] = sreg[0][i][b];
            end
        end
    end
endmodule

// File: tb/tb_mskdata_serializer_low_level.sv
// tb/tb_mskdata_serializer_low_level.sv - bench for the masked serializer with d=2, BITS=32, RFRSH_RATE=8
module tb_mskdata_serializer_low_level;
    localparam int D    = 2;
    localparam int BITS = 32;
    localparam int R    = 8;
    localparam int NST  = 4;
`ifdef SMAESH_SERIALIZER_RFRSH_EN
    localparam int EXP_RND = 3;
`else
    localparam int EXP_RND = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mskdata_serializer_low_level_if #(.d(D), .BITS(BITS), .RFRSH_RATE(R)) bus ();

    mskdata_serializer_low_level #(.d(D), .BITS(BITS), .RFRSH_RATE(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [15:0] raw;
        int          idx;
    } sb_t;

    typedef struct {
        logic [31:0]     word;
        logic [3:0][7:0] exp;
        logic [7:0]      pat;
        int              busy;
    } vec_t;

    sb_t             sbq[$];
    int              checks = 0;
    int              errors = 0;
    int              rnd_cnt = 0;
    logic [7:0]      rdy_pat = 8'hFF;
    logic [2:0]      pidx = 3'd0;
    logic [3:0][7:0] drv_exp = '0;
    logic [63:0]     drv_sh = '0;
    vec_t            vecs[5];

    function automatic logic [63:0] enc(input logic [31:0] w, input logic [31:0] m);
        logic [63:0] r;
        for (int k = 0; k < 32; k++) begin
            r[2*k]   = m[k];
            r[2*k+1] = w[k] ^ m[k];
        end
        return r;
    endfunction

    function automatic logic [7:0] unmask(input logic [15:0] c);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = c[2*b] ^ c[2*b+1];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_aux();
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready    = rdy_pat[pidx];
            pidx             = pidx + 3'd1;
            bus.rnd_rfrsh_in = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic monitor();
        sb_t         e;
        logic        hold = 1'b0;
        logic [15:0] hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 64'(bus.out_valid), 64'(1));
                    check("hold_data", 64'(bus.sh_data_out), 64'(hold_data));
                end
                hold      = bus.out_valid && !bus.out_ready;
                hold_data = bus.sh_data_out;
                if (bus.rnd_ready) rnd_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_chunk: got %0h expected none", bus.sh_data_out);
                    end else begin
                        e = sbq.pop_front();
                        check("chunk_xor", 64'(unmask(bus.sh_data_out)), 64'(e.data));
                        check("chunk_last", 64'(bus.out_last), 64'(e.last));
`ifdef SMAESH_SERIALIZER_RFRSH_EN
                        if (e.idx == 0)
                            check("chunk0_shares", 64'(bus.sh_data_out), 64'(e.raw));
                        else
                            check("chunk_refreshed", 64'(bus.sh_data_out != e.raw), 64'(1));
`else
                        check("chunk_shares", 64'(bus.sh_data_out), 64'(e.raw));
`endif
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    for (int j = 0; j < NST; j++)
                        sbq.push_back('{data: drv_exp[j], last: (j == NST - 1),
                                        raw: drv_sh[j*16 +: 16], idx: j});
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0][7:0] exp);
        int   n = 0;
        logic acc = 1'b0;
        drv_exp        = exp;
        drv_sh         = enc(w, $urandom());
        bus.sh_data_in = drv_sh;
        bus.in_valid   = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("load_accepted", 64'(acc), 64'(1));
    endtask

    task automatic wait_drain(output int busy);
        busy = 0;
        @(negedge clk);
        while (bus.out_valid && busy < 100) begin
            busy++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy;
        bus.in_valid     = 1'b0;
        bus.sh_data_in   = '0;
        bus.out_ready    = 1'b1;
        bus.rnd_rfrsh_in = 8'h01;
        fork
            monitor();
            drive_aux();
        join_none

        vecs[0] = '{word: 32'hDDCCBBAA, exp: {8'hDD, 8'hCC, 8'hBB, 8'hAA}, pat: 8'hFF,       busy: 4};
        vecs[1] = '{word: 32'hDDCCBBAA, exp: {8'hDD, 8'hCC, 8'hBB, 8'hAA}, pat: 8'b10011001, busy: 8};
        vecs[2] = '{word: 32'h01234567, exp: {8'h01, 8'h23, 8'h45, 8'h67}, pat: 8'hFF,       busy: 4};
        vecs[3] = '{word: 32'hFF00FF00, exp: {8'hFF, 8'h00, 8'hFF, 8'h00}, pat: 8'b01010101, busy: 7};
        vecs[4] = '{word: 32'h00000000, exp: {8'h00, 8'h00, 8'h00, 8'h00}, pat: 8'b10101010, busy: 8};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_out_last", 64'(bus.out_last), 64'(0));
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            rdy_pat = vecs[v].pat;
            pidx    = 3'd7;
            rnd_cnt = 0;
            send_word(vecs[v].word, vecs[v].exp);
            wait_drain(busy);
            check("busy_cycles", 64'(busy), 64'(vecs[v].busy));
            check("rnd_ready_pulses", 64'(rnd_cnt), 64'(EXP_RND));
        end

        // Back-to-back: second word loads on the first word's last-chunk cycle.
        rdy_pat        = 8'hFF;
        drv_exp        = {8'h87, 8'h65, 8'h43, 8'h21};
        drv_sh         = enc(32'h87654321, $urandom());
        bus.sh_data_in = drv_sh;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        check("b2b_idle_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        drv_exp        = {8'h0F, 8'hED, 8'hCB, 8'hA9};
        drv_sh         = enc(32'h0FEDCBA9, $urandom());
        bus.sh_data_in = drv_sh;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("b2b_valid", 64'(bus.out_valid), 64'(1));
            check("b2b_in_ready", 64'(bus.in_ready), 64'((c == 3) || (c == 7)));
            @(posedge clk);
            #1;
            if (c == 3) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_drained", 64'(bus.out_valid), 64'(0));
        check("sb_empty_b2b", 64'(sbq.size()), 64'(0));
        @(posedge clk);
        #1;

        // Reset after two chunks drops the rest of the word.
        send_word(32'hDDCCBBAA, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sbq.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_mid_out_last", 64'(bus.out_last), 64'(0));
        @(posedge clk);
        #1;
        send_word(32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11});
        wait_drain(busy);
        check("rst_restart_busy", 64'(busy), 64'(4));
        check("sb_empty_end", 64'(sbq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
